// File: rtl/spec_weight_pkg.sv
// rtl/spec_weight_pkg.sv - shared types and fixed-point helpers for the FFT bin weighting path
package spec_weight_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Width of a {imag, real} pair for a given component width
  localparam int PAIR_COMPONENTS = 2;

  // Round half-up then arithmetic shift right by sh (sh >= 1)
  function automatic longint round_half_up(input longint x, input int sh);
    longint bias;
    bias = 64'sd1 <<< (sh - 1);
    return (x + bias) >>> sh;
  endfunction

  // Clamp to the signed range of an ow-bit value
  function automatic longint sat_limit(input longint x, input int ow);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// rtl/cmul_round_sat.sv - pipeline stages 2-3: complex multiply, then round and saturate
module cmul_round_sat
  import spec_weight_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ce,
  input  logic                               in_valid,
  input  logic                               in_win,
  input  logic                               in_last,
  input  logic [PAIR_COMPONENTS*DW-1:0]      a_data,
  input  logic [PAIR_COMPONENTS*CW-1:0]      c_data,
  output logic                               mid_valid,
  output logic                               out_valid,
  output logic                               out_last,
  output logic [PAIR_COMPONENTS*OW-1:0]      out_data,
  output logic                               clip_evt
);

  // Product width: one sum/difference of two DW x CW products
  localparam int PW = DW + CW + 1;

  logic signed [PW-1:0] ar;
  logic signed [PW-1:0] ai;
  logic signed [PW-1:0] cr;
  logic signed [PW-1:0] ci;
  logic signed [PW-1:0] p_re;
  logic signed [PW-1:0] p_im;

  logic                 s2_valid;
  logic                 s2_last;
  logic signed [PW-1:0] s2_re;
  logic signed [PW-1:0] s2_im;

  longint re_r;
  longint im_r;
  longint re_s;
  longint im_s;
  logic   re_clip;
  logic   im_clip;

  // Sign-extend operands; bins outside the window see a zero weight
  always_comb begin
    ar   = PW'($signed(a_data[DW-1:0]));
    ai   = PW'($signed(a_data[2*DW-1:DW]));
    cr   = in_win ? PW'($signed(c_data[CW-1:0])) : '0;
    ci   = in_win ? PW'($signed(c_data[2*CW-1:CW])) : '0;
    p_re = ar * cr - ai * ci;
    p_im = ar * ci + ai * cr;
  end

  // Stage 2: register full-precision products
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_re    <= '0;
      s2_im    <= '0;
    end else if (ce) begin
      s2_valid <= in_valid;
      s2_last  <= in_last;
      s2_re    <= p_re;
      s2_im    <= p_im;
    end
  end

  // Round half-up, shift, clamp to the output range and flag clipping
  always_comb begin
    re_r    = round_half_up(longint'(s2_re), SHIFT);
    im_r    = round_half_up(longint'(s2_im), SHIFT);
    re_s    = sat_limit(re_r, OW);
    im_s    = sat_limit(im_r, OW);
    re_clip = (re_s != re_r);
    im_clip = (im_s != im_r);
  end

  // Stage 3: output register feeding the master stream
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (ce) begin
      out_valid <= s2_valid;
      out_last  <= s2_last;
      out_data  <= {OW'(im_s), OW'(re_s)};
    end
  end

  assign mid_valid = s2_valid;
  assign clip_evt  = ce && s2_valid && (re_clip || im_clip);

endmodule

// File: rtl/spec_weight_seq.sv
// rtl/spec_weight_seq.sv - windowed complex weighting of one FFT frame into a frame-aligned stream
module spec_weight_seq
  import spec_weight_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int NLOG2 = 12,
  parameter int SHIFT = 15
) (
  input  logic                          fft_clk,
  input  logic                          sys_rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic [NLOG2-1:0]              bin_lo,
  input  logic [NLOG2-1:0]              bin_hi,
  input  logic [PAIR_COMPONENTS*DW-1:0] s_tdata,
  input  logic [NLOG2-1:0]              s_tindex,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  output logic                          s_tready,
  output logic                          coef_rd,
  output logic [NLOG2-1:0]              coef_addr,
  input  logic [PAIR_COMPONENTS*CW-1:0] coef_data,
  output logic [PAIR_COMPONENTS*OW-1:0] m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          err_frame,
  output logic [15:0]                   sat_cnt
);

  localparam logic [NLOG2-1:0] LAST_IDX = '1;
  localparam logic [NLOG2-1:0] IDX_ONE  = NLOG2'(1);

  state_t state;
  state_t state_nxt;

  logic             cfg_mode;
  logic [NLOG2-1:0] cfg_lo;
  logic [NLOG2-1:0] cfg_hi;
  logic [NLOG2-1:0] prev_idx;

  logic ce;
  logic accept;
  logic take;
  logic in_win;
  logic idx_last;
  logic seq_bad;
  logic start_ok;

  logic                          s1_valid;
  logic                          s1_win;
  logic                          s1_last;
  logic [PAIR_COMPONENTS*DW-1:0] s1_data;

  logic s2_valid;
  logic s3_valid;
  logic s3_last;
  logic clip_evt;
  logic last_out;

  // The whole pipe moves together; it only holds when the output beat is stuck
  assign ce       = !s3_valid || m_tready;
  assign s_tready = ((state == ST_ARMED) || (state == ST_RUN)) && ce;
  assign accept   = s_tvalid && s_tready;
  assign coef_rd  = accept;

  assign in_win    = (s_tindex >= cfg_lo) && (s_tindex <= cfg_hi);
  assign coef_addr = in_win ? (s_tindex - cfg_lo) : '0;
  assign idx_last  = (s_tindex == LAST_IDX);
  assign seq_bad   = (s_tindex != (prev_idx + IDX_ONE)) || (s_tlast != idx_last);

  // While armed only index 0 opens a frame; everything else before it is dropped
  assign take     = accept && ((state == ST_RUN) || (s_tindex == '0));
  assign start_ok = (state == ST_IDLE) && start;

  assign m_tvalid   = s3_valid;
  assign m_tlast    = s3_last;
  assign last_out   = s3_valid && m_tready && s3_last;
  assign frame_done = last_out;
  assign busy       = (state != ST_IDLE);

  // State register
  always_ff @(posedge fft_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing: arm, run one frame, then re-arm or drain
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (take) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (accept && idx_last) state_nxt = cfg_mode ? ST_ARMED : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (last_out && !s1_valid && !s2_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run configuration is captured once per start
  always_ff @(posedge fft_clk) begin
    if (sys_rst) begin
      cfg_mode <= 1'b0;
      cfg_lo   <= '0;
      cfg_hi   <= '0;
    end else if (start_ok) begin
      cfg_mode <= mode;
      cfg_lo   <= bin_lo;
      cfg_hi   <= bin_hi;
    end
  end

  // Index continuity tracking; resyncs to whatever index actually arrived
  always_ff @(posedge fft_clk) begin
    if (sys_rst) begin
      prev_idx  <= '0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= accept && (state == ST_RUN) && seq_bad;
      if (take) prev_idx <= s_tindex;
    end
  end

  // Stage 1: hold the bin while its coefficient is read
  always_ff @(posedge fft_clk) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      s1_win   <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else if (ce) begin
      s1_valid <= take;
      s1_win   <= in_win;
      s1_last  <= idx_last;
      s1_data  <= s_tdata;
    end
  end

  // Saturation event counter, sticks at all-ones
  always_ff @(posedge fft_clk) begin
    if (sys_rst) begin
      sat_cnt <= '0;
    end else if (start_ok) begin
      sat_cnt <= '0;
    end else if (clip_evt && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  cmul_round_sat #(
    .DW    (DW),
    .CW    (CW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_cmul (
    .clk       (fft_clk),
    .rst       (sys_rst),
    .ce        (ce),
    .in_valid  (s1_valid),
    .in_win    (s1_win),
    .in_last   (s1_last),
    .a_data    (s1_data),
    .c_data    (coef_data),
    .mid_valid (s2_valid),
    .out_valid (s3_valid),
    .out_last  (s3_last),
    .out_data  (m_tdata),
    .clip_evt  (clip_evt)
  );

endmodule

// File: tb/tb_spec_weight_seq.sv
// tb/tb_spec_weight_seq.sv - randomized self-checking bench for spec_weight_seq
module tb_spec_weight_seq;

  localparam int N = 16;

  logic        fft_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  bin_lo = '0;
  logic [3:0]  bin_hi = '0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tindex = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        coef_rd;
  logic [3:0]  coef_addr;
  logic [31:0] coef_data = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic        err_frame;
  logic [15:0] sat_cnt;

  always #5 fft_clk = ~fft_clk;

  spec_weight_seq #(.DW(16), .CW(16), .OW(16), .NLOG2(4), .SHIFT(15)) dut (
    .fft_clk(fft_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
    .bin_lo(bin_lo), .bin_hi(bin_hi), .s_tdata(s_tdata), .s_tindex(s_tindex),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .coef_rd(coef_rd), .coef_addr(coef_addr), .coef_data(coef_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .frame_done(frame_done), .err_frame(err_frame), .sat_cnt(sat_cnt)
  );

  // Coefficient RAM: one-cycle read latency, output held between reads
  logic [31:0] coef_mem [N];
  always @(posedge fft_clk) if (coef_rd) coef_data <= coef_mem[coef_addr];

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       src_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  int checks = 0;
  int errors = 0;
  int cfg_mode, cfg_lo, cfg_hi;
  int m_active, m_prev, m_stop;
  int exp_err, exp_done, exp_sat;
  int got_err, got_done, idle_cyc, timed_out;

  // Reference: weighted, rounded, clamped value of one bin as {last, imag, real}
  task automatic model_beat(input int idx, input logic [31:0] d, output logic [32:0] e);
    longint ar, ai, cr, ci, re, im;
    logic [31:0] c;
    logic clip;
    c = (idx >= cfg_lo && idx <= cfg_hi) ? coef_mem[idx - cfg_lo] : 32'd0;
    ar = longint'($signed(d[15:0]));
    ai = longint'($signed(d[31:16]));
    cr = longint'($signed(c[15:0]));
    ci = longint'($signed(c[31:16]));
    re = ((ar * cr - ai * ci) + 16384) >>> 15;
    im = ((ar * ci + ai * cr) + 16384) >>> 15;
    clip = 1'b0;
    if (re > 32767) begin re = 32767; clip = 1'b1; end
    if (re < -32768) begin re = -32768; clip = 1'b1; end
    if (im > 32767) begin im = 32767; clip = 1'b1; end
    if (im < -32768) begin im = -32768; clip = 1'b1; end
    if (clip) exp_sat++;
    e = {(idx == N - 1), im[15:0], re[15:0]};
  endtask

  // Reference frame rules applied to each accepted input beat
  task automatic model_accept(input beat_t b);
    logic [32:0] e;
    if (m_active == 0) begin
      if (b.idx == 0) begin
        m_active = 1;
        m_prev = 0;
        model_beat(b.idx, b.data, e);
        exp_q.push_back(e);
      end
    end else begin
      if (b.idx != m_prev + 1 || b.last != (b.idx == N - 1)) exp_err++;
      m_prev = b.idx;
      model_beat(b.idx, b.data, e);
      exp_q.push_back(e);
      if (b.idx == N - 1) begin
        exp_done++;
        m_active = 0;
        if (cfg_mode == 0) m_stop = 1;
      end
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    start = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(negedge fft_clk);
    sys_rst = 1'b0;
  endtask

  task automatic do_start(input int md, input int lo, input int hi);
    cfg_mode = md; cfg_lo = lo; cfg_hi = hi;
    m_active = 0; m_stop = 0; exp_err = 0; exp_done = 0; exp_sat = 0;
    got_err = 0; got_done = 0; idle_cyc = 0; timed_out = 0;
    exp_q.delete();
    got_q.delete();
    mode = md[0];
    bin_lo = 4'(lo);
    bin_hi = 4'(hi);
    start = 1'b1;
    @(negedge fft_clk);
    start = 1'b0;
  endtask

  task automatic push_beat(input int idx, input logic [31:0] d);
    beat_t b;
    b.idx = idx; b.data = d; b.last = (idx == N - 1);
    src_q.push_back(b);
  endtask

  task automatic rand_coefs();
    for (int i = 0; i < N; i++) coef_mem[i] = $urandom;
  endtask

  // Feed src_q with valid gaps and the chosen m_tready pattern, collect outputs
  task automatic run_stream(input int rdy_mode, input int gap);
    int budget;
    logic tog, acc;
    budget = 3000;
    tog = 1'b0;
    s_tvalid = 1'b0;
    while (1) begin
      if (!s_tvalid && src_q.size() > 0 && m_stop == 0 && $urandom_range(0, 99) >= gap) begin
        s_tvalid = 1'b1;
        s_tindex = 4'(src_q[0].idx);
        s_tdata = src_q[0].data;
        s_tlast = src_q[0].last;
      end
      tog = ~tog;
      m_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : 1'($urandom_range(0, 1));
      #1;
      acc = s_tvalid && s_tready;
      if (acc) model_accept(src_q.pop_front());
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (frame_done) got_done++;
      if (err_frame) got_err++;
      if (!busy) idle_cyc++;
      @(negedge fft_clk);
      if (acc) s_tvalid = 1'b0;
      budget--;
      if (budget == 0) begin timed_out = 1; break; end
      if ((src_q.size() == 0 || m_stop != 0) && got_q.size() >= exp_q.size() && (cfg_mode == 1 || !busy)) break;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    src_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({m_tvalid, m_tlast, busy, frame_done, err_frame, s_tready, coef_rd} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000000", {m_tvalid, m_tlast, busy, frame_done, err_frame, s_tready, coef_rd});
    end
    checks++;
    if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", m_tdata); end
    checks++;
    if (sat_cnt !== 16'h0) begin errors++; $display("FAIL reset_sat_cnt got %h exp 0", sat_cnt); end
    @(negedge fft_clk);
  endtask

  task automatic test_window();
    logic [32:0] e;
    int er;
    do_reset();
    for (int i = 0; i < N; i++) coef_mem[i] = {16'h0000, 16'h7FFF};
    do_start(0, 2, 5);
    for (int k = 0; k < N; k++) push_beat(k, {16'h0000, 16'(k)});
    run_stream(0, 0);
    checks++;
    if (got_q.size() != 16) begin errors++; $display("FAIL window_count got %0d exp 16", got_q.size()); end
    for (int k = 0; k < N && k < got_q.size(); k++) begin
      er = (k >= 2 && k <= 5) ? k : 0;
      e = {(k == 15), 16'h0000, 16'(er)};
      checks++;
      if (got_q[k] !== e) begin errors++; $display("FAIL window_bin%0d got %h exp %h", k, got_q[k], e); end
    end
    checks++;
    if (got_done != 1 || got_err != 0 || idle_cyc != 0 || busy !== 1'b0 || timed_out != 0) begin
      errors++;
      $display("FAIL window_ctrl got done=%0d err=%0d idle=%0d busy=%b to=%0d exp 1 0 0 0 0", got_done, got_err, idle_cyc, busy, timed_out);
    end
  endtask

  task automatic test_arith();
    do_reset();
    rand_coefs();
    coef_mem[0] = {16'h7FFF, 16'h0000};
    coef_mem[1] = {16'h7FFF, 16'h7FFF};
    do_start(0, 0, 15);
    push_beat(0, {16'h0000, 16'd100});
    push_beat(1, {16'h7FFF, 16'h7FFF});
    for (int k = 2; k < N; k++) push_beat(k, $urandom);
    run_stream(0, 30);
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 16) begin
      errors++; $display("FAIL arith_count got %0d exp 16", got_q.size());
    end
    checks++;
    if (got_q.size() > 1 && got_q[0] !== {1'b0, 16'd100, 16'd0}) begin errors++; $display("FAIL arith_j got %h exp 0_0064_0000", got_q[0]); end
    checks++;
    if (got_q.size() > 1 && got_q[1] !== {1'b0, 16'h7FFF, 16'h0000}) begin errors++; $display("FAIL arith_clip got %h exp 0_7fff_0000", got_q[1]); end
    for (int i = 2; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL arith_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (sat_cnt !== 16'(exp_sat) || sat_cnt == 16'd0) begin errors++; $display("FAIL arith_sat_cnt got %0d exp %0d", sat_cnt, exp_sat); end
    checks++;
    if (timed_out != 0) begin errors++; $display("FAIL arith_timeout got expired exp done"); end
  endtask

  task automatic test_backpressure();
    int lo, hi;
    do_reset();
    rand_coefs();
    lo = $urandom_range(0, 7);
    hi = $urandom_range(lo, 15);
    do_start(0, lo, hi);
    for (int k = 0; k < N; k++) push_beat(k, $urandom);
    run_stream(1, 40);
    checks++;
    if (got_q.size() != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (got_done != 1 || sat_cnt !== 16'(exp_sat) || timed_out != 0) begin
      errors++; $display("FAIL bp_ctrl got done=%0d sat=%0d to=%0d exp 1 %0d 0", got_done, sat_cnt, timed_out, exp_sat);
    end
  endtask

  task automatic test_resync();
    do_reset();
    rand_coefs();
    do_start(0, 0, 15);
    for (int k = 7; k < N; k++) push_beat(k, $urandom);
    for (int k = 0; k < N; k++) if (k != 9) push_beat(k, $urandom);
    run_stream(2, 20);
    checks++;
    if (got_q.size() != 15 || exp_q.size() != 15) begin errors++; $display("FAIL resync_count got %0d exp 15", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL resync_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (got_err != 1 || exp_err != 1) begin errors++; $display("FAIL resync_err got %0d exp 1", got_err); end
    checks++;
    if (got_done != 1 || timed_out != 0) begin errors++; $display("FAIL resync_done got %0d to=%0d exp 1 0", got_done, timed_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rand_coefs();
    do_start(1, 3, 12);
    for (int f = 0; f < 3; f++) for (int k = 0; k < N; k++) push_beat(k, $urandom);
    run_stream(2, 10);
    checks++;
    if (got_q.size() != 48) begin errors++; $display("FAIL b2b_count got %0d exp 48", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i][32] !== (i % 16 == 15)) begin
        errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_done != 3) begin errors++; $display("FAIL b2b_frame_done got %0d exp 3", got_done); end
    checks++;
    if (idle_cyc != 0 || busy !== 1'b1 || got_err != 0 || timed_out != 0) begin
      errors++; $display("FAIL b2b_busy got idle=%0d busy=%b err=%0d to=%0d exp 0 1 0 0", idle_cyc, busy, got_err, timed_out);
    end
  endtask

  task automatic test_reset_mid();
    int cnt, idx, budget;
    logic acc;
    do_reset();
    rand_coefs();
    do_start(0, 0, 15);
    cnt = 0; idx = 0; budget = 200;
    m_tready = 1'b1;
    while (cnt < 8 && budget > 0) begin
      s_tvalid = 1'b1;
      s_tindex = 4'(idx);
      s_tdata = $urandom;
      s_tlast = (idx == N - 1);
      #1;
      acc = s_tvalid && s_tready;
      @(negedge fft_clk);
      if (acc) begin cnt++; idx++; end
      budget--;
    end
    checks++;
    if (cnt != 8) begin errors++; $display("FAIL rstmid_feed got %0d exp 8", cnt); end
    sys_rst = 1'b1;
    @(negedge fft_clk);
    #1;
    checks++;
    if ({m_tvalid, m_tlast, busy, frame_done, err_frame, s_tready, coef_rd} !== 7'b0 || m_tdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got %b %h exp 0000000 0", {m_tvalid, m_tlast, busy, frame_done, err_frame, s_tready, coef_rd}, m_tdata);
    end
    @(negedge fft_clk);
    sys_rst = 1'b0;
    s_tvalid = 1'b0;
    @(negedge fft_clk);
    do_start(0, 10, 3);
    for (int k = 0; k < N; k++) push_beat(k, $urandom);
    run_stream(2, 20);
    checks++;
    if (got_q.size() != 16) begin errors++; $display("FAIL empty_count got %0d exp 16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {(i == 15), 32'h0}) begin errors++; $display("FAIL empty_beat%0d got %h exp %h", i, got_q[i], {(i == 15), 32'h0}); end
    end
    checks++;
    if (got_done != 1 || sat_cnt !== 16'h0 || timed_out != 0) begin
      errors++; $display("FAIL empty_ctrl got done=%0d sat=%0d to=%0d exp 1 0 0", got_done, sat_cnt, timed_out);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_arith();
    test_backpressure();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
